mmu_dbus_xlate: RTL and testbench



---
 rtl/mmu_pkg.sv | 49 ++++
 rtl/mmu_seg_decode.sv | 43 ++++
 rtl/mmu_dbus_xlate.sv | 252 +++++++++++++++++++++++++
 tb/tb_mmu_dbus_xlate.sv | 451 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmu_pkg.sv
// ---------------------------------------------------------------------------
// mmu_pkg
// Shared types and constants for the data-side (and later instruction-side)
// MIPS address translation blocks.
//   mmu_state_e    : sequencer states IDLE / XLATE / BUS / RESP
//   EXC_*          : CP0 ExcCode values reported with an exception response
//   KSEG0_BASE     : first unmapped kernel address (kseg0)
//   KSEG2_BASE     : first mapped kernel address after kseg1 (kseg2)
//   UNMAPPED_MASK  : strips the segment bits from a kseg0/kseg1 address
//   is_misaligned(): alignment check for a given access size
// ---------------------------------------------------------------------------
package mmu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_XLATE = 2'd1,
        ST_BUS   = 2'd2,
        ST_RESP  = 2'd3
    } mmu_state_e;

    localparam logic [4:0] EXC_NONE = 5'd0;
    localparam logic [4:0] EXC_TLBL = 5'd2;
    localparam logic [4:0] EXC_TLBS = 5'd3;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_DBE  = 5'd7;

    localparam logic [31:0] KSEG0_BASE    = 32'h8000_0000;
    localparam logic [31:0] KSEG2_BASE    = 32'hC000_0000;
    localparam logic [31:0] UNMAPPED_MASK = 32'h1FFF_FFFF;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;

    // Size encoding 3 is deliberately folded into the word case so that an
    // out-of-range size behaves exactly like a word access.
    function automatic logic is_misaligned(input logic [1:0] addr_lo,
                                           input logic [1:0] size);
        logic mis;
        mis = 1'b0;
        case (size)
            SIZE_BYTE: mis = 1'b0;
            SIZE_HALF: mis = addr_lo[0];
            default:   mis = (addr_lo != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mmu_seg_decode.sv
// ---------------------------------------------------------------------------
// mmu_seg_decode
// Combinational MIPS segment classifier, shared by the data and instruction
// translation paths.
//   vaddr_i          : virtual address under test
//   user_mode_i      : CP0 Status.UM captured with the request
//   size_i           : access size (0 byte, 1 half, 2/3 word)
//   we_i             : 1 for a store, selects AdES over AdEL
//   mapped_o         : address must go through the TLB
//   unmapped_paddr_o : physical address for kseg0/kseg1
//   addr_exc_o       : address error (misaligned or user access to kernel)
//   exccode_o        : AdEL/AdES when addr_exc_o, otherwise 0
// ---------------------------------------------------------------------------
module mmu_seg_decode
    import mmu_pkg::*;
(
    input  logic [31:0] vaddr_i,
    input  logic        user_mode_i,
    input  logic [1:0]  size_i,
    input  logic        we_i,
    output logic        mapped_o,
    output logic [31:0] unmapped_paddr_o,
    output logic        addr_exc_o,
    output logic [4:0]  exccode_o
);

    logic in_kseg01;
    logic addr_err;

    // Address errors take priority over segment classification; a user-mode
    // access to any address with bit 31 set is an address error, not a TLB
    // lookup.
    always_comb begin
        in_kseg01        = (vaddr_i >= KSEG0_BASE) && (vaddr_i < KSEG2_BASE);
        addr_err         = is_misaligned(vaddr_i[1:0], size_i) ||
                           (user_mode_i && vaddr_i[31]);
        mapped_o         = !in_kseg01;
        unmapped_paddr_o = vaddr_i & UNMAPPED_MASK;
        addr_exc_o       = addr_err;
        exccode_o        = addr_err ? (we_i ? EXC_ADES : EXC_ADEL) : EXC_NONE;
    end

endmodule

// File: rtl/mmu_dbus_xlate.sv
// ---------------------------------------------------------------------------
// mmu_dbus_xlate
// Data-side translation and bus sequencer between the LSU and the data bus.
// Accepts one request at a time, translates it (direct for kseg0/kseg1, via
// the TLB data port otherwise), runs the bus transfer and returns exactly one
// response per request: load data or an exception record for CP0.
//   clk_i / rst_i                 : clock, synchronous active-high reset
//   req_*_i, user_mode_i          : LSU request, req_ready_o in IDLE only
//   tlb_vaddr_o                   : latched vaddr to the TLB data port
//   tlb_paddr_i / tlb_miss_i      : TLB lookup result for tlb_vaddr_o
//   bus_req_o, bus_addr/we/be/wdata_o : registered bus command
//   bus_ack_i / bus_err_i / bus_rdata_i : bus completion
//   rsp_*_o                       : one-cycle response pulse
// Parameter BUS_TIMEOUT (1..65535): cycles bus_req_o stays high without
// ack/err before a bus-error response is returned.
// ---------------------------------------------------------------------------
module mmu_dbus_xlate
    import mmu_pkg::*;
#(
    parameter int unsigned BUS_TIMEOUT = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [31:0] req_addr_i,
    input  logic        req_we_i,
    input  logic [1:0]  req_size_i,
    input  logic [31:0] req_wdata_i,
    input  logic [3:0]  req_be_i,
    input  logic        user_mode_i,
    output logic [31:0] tlb_vaddr_o,
    input  logic [31:0] tlb_paddr_i,
    input  logic        tlb_miss_i,
    output logic        bus_req_o,
    output logic [31:0] bus_addr_o,
    output logic        bus_we_o,
    output logic [3:0]  bus_be_o,
    output logic [31:0] bus_wdata_o,
    input  logic        bus_ack_i,
    input  logic        bus_err_i,
    input  logic [31:0] bus_rdata_i,
    output logic        rsp_valid_o,
    output logic        rsp_exc_o,
    output logic [4:0]  rsp_exccode_o,
    output logic [31:0] rsp_badvaddr_o,
    output logic [31:0] rsp_rdata_o
);

    mmu_state_e  state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic        we_q, we_d;
    logic [1:0]  size_q, size_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic        um_q, um_d;
    logic [15:0] timeout_cnt_q, timeout_cnt_d;
    logic        bus_req_q, bus_req_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic        bus_we_q, bus_we_d;
    logic [3:0]  bus_be_q, bus_be_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_exc_q, rsp_exc_d;
    logic [4:0]  rsp_exccode_q, rsp_exccode_d;
    logic [31:0] rsp_badvaddr_q, rsp_badvaddr_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;

    logic        seg_mapped;
    logic [31:0] seg_unmapped_paddr;
    logic        seg_addr_exc;
    logic [4:0]  seg_exccode;

    logic        exc_hit;
    logic [4:0]  exc_code;
    logic [16:0] timeout_cnt_next;

    mmu_seg_decode u_seg_decode (
        .vaddr_i          (addr_q),
        .user_mode_i      (um_q),
        .size_i           (size_q),
        .we_i             (we_q),
        .mapped_o         (seg_mapped),
        .unmapped_paddr_o (seg_unmapped_paddr),
        .addr_exc_o       (seg_addr_exc),
        .exccode_o        (seg_exccode)
    );

    // Next-state and next-output logic. Every register holds by default; each
    // state only overrides what it changes. The response fields are cleared
    // on leaving RESP so they read as zero whenever rsp_valid_o is low.
    always_comb begin
        state_d          = state_q;
        addr_d           = addr_q;
        we_d             = we_q;
        size_d           = size_q;
        wdata_d          = wdata_q;
        be_d             = be_q;
        um_d             = um_q;
        timeout_cnt_d    = timeout_cnt_q;
        bus_req_d        = bus_req_q;
        bus_addr_d       = bus_addr_q;
        bus_we_d         = bus_we_q;
        bus_be_d         = bus_be_q;
        bus_wdata_d      = bus_wdata_q;
        rsp_valid_d      = rsp_valid_q;
        rsp_exc_d        = rsp_exc_q;
        rsp_exccode_d    = rsp_exccode_q;
        rsp_badvaddr_d   = rsp_badvaddr_q;
        rsp_rdata_d      = rsp_rdata_q;
        exc_hit          = 1'b0;
        exc_code         = EXC_NONE;
        // One extra bit so BUS_TIMEOUT = 65535 compares without wrapping.
        timeout_cnt_next = {1'b0, timeout_cnt_q} + 17'd1;

        case (state_q)
            ST_IDLE: begin
                if (req_valid_i) begin
                    addr_d  = req_addr_i;
                    we_d    = req_we_i;
                    size_d  = req_size_i;
                    wdata_d = req_wdata_i;
                    be_d    = req_be_i;
                    um_d    = user_mode_i;
                    state_d = ST_XLATE;
                end
            end

            ST_XLATE: begin
                if (seg_addr_exc) begin
                    exc_hit  = 1'b1;
                    exc_code = seg_exccode;
                end else if (seg_mapped && tlb_miss_i) begin
                    exc_hit  = 1'b1;
                    exc_code = we_q ? EXC_TLBS : EXC_TLBL;
                end

                if (exc_hit) begin
                    state_d        = ST_RESP;
                    rsp_valid_d    = 1'b1;
                    rsp_exc_d      = 1'b1;
                    rsp_exccode_d  = exc_code;
                    rsp_badvaddr_d = addr_q;
                    rsp_rdata_d    = 32'd0;
                end else begin
                    state_d       = ST_BUS;
                    bus_req_d     = 1'b1;
                    bus_addr_d    = seg_mapped ? tlb_paddr_i : seg_unmapped_paddr;
                    bus_we_d      = we_q;
                    bus_be_d      = be_q;
                    bus_wdata_d   = wdata_q;
                    timeout_cnt_d = 16'd0;
                end
            end

            ST_BUS: begin
                // The cycle whose incremented count would reach BUS_TIMEOUT is
                // the last one with bus_req high, giving exactly BUS_TIMEOUT
                // request cycles.
                if (bus_err_i || bus_ack_i ||
                    (timeout_cnt_next == 17'(BUS_TIMEOUT))) begin
                    state_d        = ST_RESP;
                    bus_req_d      = 1'b0;
                    rsp_valid_d    = 1'b1;
                    rsp_badvaddr_d = 32'd0;
                    if (bus_ack_i && !bus_err_i) begin
                        rsp_exc_d     = 1'b0;
                        rsp_exccode_d = EXC_NONE;
                        rsp_rdata_d   = we_q ? 32'd0 : bus_rdata_i;
                    end else begin
                        rsp_exc_d     = 1'b1;
                        rsp_exccode_d = EXC_DBE;
                        rsp_rdata_d   = 32'd0;
                    end
                end else begin
                    timeout_cnt_d = timeout_cnt_next[15:0];
                end
            end

            ST_RESP: begin
                state_d        = ST_IDLE;
                rsp_valid_d    = 1'b0;
                rsp_exc_d      = 1'b0;
                rsp_exccode_d  = EXC_NONE;
                rsp_badvaddr_d = 32'd0;
                rsp_rdata_d    = 32'd0;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers. Reset abandons any in-flight request, so
    // no response is ever produced for it.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q        <= ST_IDLE;
            addr_q         <= 32'd0;
            we_q           <= 1'b0;
            size_q         <= 2'd0;
            wdata_q        <= 32'd0;
            be_q           <= 4'd0;
            um_q           <= 1'b0;
            timeout_cnt_q  <= 16'd0;
            bus_req_q      <= 1'b0;
            bus_addr_q     <= 32'd0;
            bus_we_q       <= 1'b0;
            bus_be_q       <= 4'd0;
            bus_wdata_q    <= 32'd0;
            rsp_valid_q    <= 1'b0;
            rsp_exc_q      <= 1'b0;
            rsp_exccode_q  <= EXC_NONE;
            rsp_badvaddr_q <= 32'd0;
            rsp_rdata_q    <= 32'd0;
        end else begin
            state_q        <= state_d;
            addr_q         <= addr_d;
            we_q           <= we_d;
            size_q         <= size_d;
            wdata_q        <= wdata_d;
            be_q           <= be_d;
            um_q           <= um_d;
            timeout_cnt_q  <= timeout_cnt_d;
            bus_req_q      <= bus_req_d;
            bus_addr_q     <= bus_addr_d;
            bus_we_q       <= bus_we_d;
            bus_be_q       <= bus_be_d;
            bus_wdata_q    <= bus_wdata_d;
            rsp_valid_q    <= rsp_valid_d;
            rsp_exc_q      <= rsp_exc_d;
            rsp_exccode_q  <= rsp_exccode_d;
            rsp_badvaddr_q <= rsp_badvaddr_d;
            rsp_rdata_q    <= rsp_rdata_d;
        end
    end

    assign req_ready_o    = (state_q == ST_IDLE);
    assign tlb_vaddr_o    = addr_q;
    assign bus_req_o      = bus_req_q;
    assign bus_addr_o     = bus_addr_q;
    assign bus_we_o       = bus_we_q;
    assign bus_be_o       = bus_be_q;
    assign bus_wdata_o    = bus_wdata_q;
    assign rsp_valid_o    = rsp_valid_q;
    assign rsp_exc_o      = rsp_exc_q;
    assign rsp_exccode_o  = rsp_exccode_q;
    assign rsp_badvaddr_o = rsp_badvaddr_q;
    assign rsp_rdata_o    = rsp_rdata_q;

endmodule

// File: tb/tb_mmu_dbus_xlate.sv
// ---------------------------------------------------------------------------
// tb_mmu_dbus_xlate
// Drives directed and random LSU requests into mmu_dbus_xlate (with a short
// bus timeout) and checks every cycle against a transaction-level model of
// what the block must do: when it is busy, when bus_req is up and with what
// command, and when and what it responds. The TLB is emulated as
// paddr = vaddr ^ key with a per-request key and miss flag.
// ---------------------------------------------------------------------------
module tb_mmu_dbus_xlate;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        req_we;
    logic [1:0]  req_size;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        user_mode;
    logic [31:0] tlb_vaddr;
    logic [31:0] tlb_paddr;
    logic        tlb_miss;
    logic        bus_req;
    logic [31:0] bus_addr;
    logic        bus_we;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic        bus_err;
    logic [31:0] bus_rdata;
    logic        rsp_valid;
    logic        rsp_exc;
    logic [4:0]  rsp_exccode;
    logic [31:0] rsp_badvaddr;
    logic [31:0] rsp_rdata;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    logic chk_en = 1'b0;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [1:0]  size;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        um;
        logic        miss;
        logic [31:0] key;
        int          k;
        logic        err;
        logic        err_ack;
        logic [31:0] rdata;
        int          gap;
    } txn_t;

    // Model of the transaction currently in flight
    int          m_acc  = -100;
    int          m_rsp  = -100;
    int          m_nbus = 0;
    int          m_k    = 0;
    logic        m_err  = 1'b0;
    logic        m_err_ack = 1'b0;
    logic [31:0] m_busdata = 32'd0;
    logic        m_miss = 1'b0;
    logic [31:0] m_key  = 32'd0;
    logic [31:0] m_vaddr = 32'd0;
    logic [31:0] m_paddr = 32'd0;
    logic        m_we = 1'b0;
    logic [3:0]  m_be = 4'd0;
    logic [31:0] m_wdata = 32'd0;
    logic        m_exc = 1'b0;
    logic [4:0]  m_code = 5'd0;
    logic [31:0] m_bad = 32'd0;
    logic [31:0] m_rdata = 32'd0;

    // Observations recorded by the compare process for literal pins
    int          last_rsp_cyc = -1;
    logic        last_exc;
    logic [4:0]  last_code;
    logic [31:0] last_bad;
    logic [31:0] last_rdata;
    logic [31:0] last_bus_addr;
    int          bus_cnt = 0;

    assign tlb_paddr = tlb_vaddr ^ m_key;
    assign tlb_miss  = m_miss;

    mmu_dbus_xlate #(.BUS_TIMEOUT(TMO)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .req_valid_i    (req_valid),
        .req_ready_o    (req_ready),
        .req_addr_i     (req_addr),
        .req_we_i       (req_we),
        .req_size_i     (req_size),
        .req_wdata_i    (req_wdata),
        .req_be_i       (req_be),
        .user_mode_i    (user_mode),
        .tlb_vaddr_o    (tlb_vaddr),
        .tlb_paddr_i    (tlb_paddr),
        .tlb_miss_i     (tlb_miss),
        .bus_req_o      (bus_req),
        .bus_addr_o     (bus_addr),
        .bus_we_o       (bus_we),
        .bus_be_o       (bus_be),
        .bus_wdata_o    (bus_wdata),
        .bus_ack_i      (bus_ack),
        .bus_err_i      (bus_err),
        .bus_rdata_i    (bus_rdata),
        .rsp_valid_o    (rsp_valid),
        .rsp_exc_o      (rsp_exc),
        .rsp_exccode_o  (rsp_exccode),
        .rsp_badvaddr_o (rsp_badvaddr),
        .rsp_rdata_o    (rsp_rdata)
    );

    always #5 clk = ~clk;

    // Edge counter: after edge n, cyc reads n for the rest of that cycle.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Compare process: every cycle, 2ns after the edge, the DUT outputs are
    // held against what the model says the current cycle should show.
    always @(posedge clk) begin
        int   c;
        logic busy;
        logic on_bus;
        #2;
        if (chk_en) begin
            c      = cyc;
            busy   = (c >= m_acc) && (c <= m_rsp);
            on_bus = (m_nbus > 0) && (c >= m_acc + 1) && (c <= m_acc + m_nbus);
            checkOutput("req_ready", 32'(req_ready), 32'(!busy));
            checkOutput("bus_req", 32'(bus_req), 32'(on_bus));
            if (c == m_acc) begin
                bus_cnt = 0;
                checkOutput("tlb_vaddr", tlb_vaddr, m_vaddr);
            end
            if (bus_req === 1'b1) bus_cnt++;
            if (on_bus) begin
                checkOutput("bus_addr", bus_addr, m_paddr);
                checkOutput("bus_we", 32'(bus_we), 32'(m_we));
                checkOutput("bus_be", 32'(bus_be), 32'(m_be));
                checkOutput("bus_wdata", bus_wdata, m_wdata);
                last_bus_addr = bus_addr;
            end
            checkOutput("rsp_valid", 32'(rsp_valid), 32'(c == m_rsp));
            if (c == m_rsp) begin
                checkOutput("rsp_exc", 32'(rsp_exc), 32'(m_exc));
                checkOutput("rsp_exccode", 32'(rsp_exccode), 32'(m_code));
                checkOutput("rsp_badvaddr", rsp_badvaddr, m_bad);
                checkOutput("rsp_rdata", rsp_rdata, m_rdata);
                last_rsp_cyc = c;
                last_exc     = rsp_exc;
                last_code    = rsp_exccode;
                last_bad     = rsp_badvaddr;
                last_rdata   = rsp_rdata;
            end
        end
    end

    // Bus side stimulus for the cycle that has just begun: the scheduled
    // ack/err inside the model's bus window, random noise outside it.
    task automatic driveBus();
        int e;
        e = cyc;
        bus_ack   = 1'b0;
        bus_err   = 1'b0;
        bus_rdata = $urandom;
        if ((m_nbus > 0) && (e >= m_acc + 1) && (e <= m_acc + m_nbus)) begin
            if ((m_k < TMO) && (e == m_acc + 1 + m_k)) begin
                if (m_err) begin
                    bus_err = 1'b1;
                    bus_ack = m_err_ack;
                end else begin
                    bus_ack   = 1'b1;
                    bus_rdata = m_busdata;
                end
            end
        end else begin
            bus_ack = ($urandom % 4) == 0;
            bus_err = ($urandom % 6) == 0;
        end
    endtask

    // Present a request and work out from the architectural rules what the
    // block must do with it.
    task automatic startTxn(input txn_t t);
        int   eff_size;
        logic mis;
        eff_size = (t.size == 2'd3) ? 2 : int'(t.size);
        mis = ((eff_size == 1) && (t.addr % 2 != 0)) ||
              ((eff_size == 2) && (t.addr % 4 != 0));

        m_acc     = cyc + 1;
        m_vaddr   = t.addr;
        m_we      = t.we;
        m_be      = t.be;
        m_wdata   = t.wdata;
        m_miss    = t.miss;
        m_key     = t.key;
        m_k       = t.k;
        m_err     = t.err;
        m_err_ack = t.err_ack;
        m_busdata = t.rdata;
        m_exc     = 1'b0;
        m_code    = 5'd0;
        m_bad     = 32'd0;
        m_rdata   = 32'd0;
        m_nbus    = 0;
        m_paddr   = 32'd0;

        if (mis || (t.um && t.addr >= 32'h8000_0000)) begin
            m_exc  = 1'b1;
            m_code = t.we ? 5'd5 : 5'd4;
            m_bad  = t.addr;
        end else if (t.addr >= 32'h8000_0000 && t.addr < 32'hC000_0000) begin
            m_paddr = t.addr - ((t.addr >= 32'hA000_0000) ? 32'hA000_0000 : 32'h8000_0000);
        end else if (t.miss) begin
            m_exc  = 1'b1;
            m_code = t.we ? 5'd3 : 5'd2;
            m_bad  = t.addr;
        end else begin
            m_paddr = t.addr ^ t.key;
        end

        if (!m_exc) begin
            if (t.k < TMO) begin
                m_nbus = t.k + 1;
                if (t.err) begin
                    m_exc  = 1'b1;
                    m_code = 5'd7;
                end else begin
                    m_rdata = t.we ? 32'd0 : t.rdata;
                end
            end else begin
                m_nbus = TMO;
                m_exc  = 1'b1;
                m_code = 5'd7;
            end
        end
        m_rsp = m_acc + 1 + m_nbus;

        req_valid = 1'b1;
        req_addr  = t.addr;
        req_we    = t.we;
        req_size  = t.size;
        req_wdata = t.wdata;
        req_be    = t.be;
        user_mode = t.um;
        driveBus();
    endtask

    // Run one request to completion plus its idle gap; returns at the first
    // cycle where the next request may be presented.
    task automatic applyStimulus(input txn_t t);
        startTxn(t);
        for (int i = 0; i < m_nbus + 3 + t.gap; i++) begin
            @(negedge clk);
            req_valid = 1'b0;
            req_addr  = $urandom;
            req_we    = 1'($urandom);
            req_size  = 2'($urandom);
            req_wdata = $urandom;
            req_be    = 4'($urandom);
            user_mode = 1'($urandom);
            driveBus();
        end
    endtask

    function automatic txn_t mk(input logic [31:0] addr, input logic we,
                                input logic [1:0] size, input logic um);
        txn_t t;
        t.addr    = addr;
        t.we      = we;
        t.size    = size;
        t.wdata   = 32'hA5A5_0000 | (addr & 32'hFFFF);
        t.be      = 4'hF;
        t.um      = um;
        t.miss    = 1'b0;
        t.key     = 32'h0;
        t.k       = 0;
        t.err     = 1'b0;
        t.err_ack = 1'b0;
        t.rdata   = 32'h0;
        t.gap     = 0;
        return t;
    endfunction

    function automatic txn_t randTxn();
        txn_t        t;
        logic [31:0] a;
        int          seg;
        seg = int'($urandom % 4);
        case (seg)
            0:       a = $urandom & 32'h7FFF_FFFF;
            1:       a = 32'h8000_0000 | ($urandom & 32'h1FFF_FFFF);
            2:       a = 32'hA000_0000 | ($urandom & 32'h1FFF_FFFF);
            default: a = 32'hC000_0000 | ($urandom & 32'h3FFF_FFFF);
        endcase
        if ($urandom % 4 != 0) a = a & 32'hFFFF_FFFC;
        t         = mk(a, 1'($urandom), 2'($urandom), ($urandom % 4) == 0);
        t.wdata   = $urandom;
        t.be      = 4'($urandom);
        t.miss    = ($urandom % 10) < 3;
        t.key     = $urandom;
        t.k       = int'($urandom % 7);
        t.err     = ($urandom % 7) == 0;
        t.err_ack = 1'($urandom);
        t.rdata   = $urandom;
        t.gap     = int'($urandom % 3);
        return t;
    endfunction

    initial begin
        txn_t t;
        rst       = 1'b1;
        req_valid = 1'b0;
        req_addr  = 32'd0;
        req_we    = 1'b0;
        req_size  = 2'd0;
        req_wdata = 32'd0;
        req_be    = 4'd0;
        user_mode = 1'b0;
        bus_ack   = 1'b0;
        bus_err   = 1'b0;
        bus_rdata = 32'd0;

        // Reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_req_ready", 32'(req_ready), 32'd1);
        checkOutput("reset_bus_req", 32'(bus_req), 32'd0);
        checkOutput("reset_bus_addr", bus_addr, 32'd0);
        checkOutput("reset_tlb_vaddr", tlb_vaddr, 32'd0);
        checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("reset_rsp_fields",
                    32'({rsp_exc, rsp_exccode}) | rsp_badvaddr | rsp_rdata, 32'd0);
        rst    = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);

        // Load word from kseg0, acked in the first bus cycle
        t = mk(32'h8000_1000, 1'b0, 2'd2, 1'b0);
        t.rdata = 32'hDEAD_BEEF;
        applyStimulus(t);
        checkOutput("t1_latency", 32'(last_rsp_cyc - m_acc), 32'd2);
        checkOutput("t1_bus_addr", last_bus_addr, 32'h0000_1000);
        checkOutput("t1_rdata", last_rdata, 32'hDEAD_BEEF);

        // Misaligned halfword store
        t = mk(32'h0040_0001, 1'b1, 2'd1, 1'b0);
        applyStimulus(t);
        checkOutput("t2_code", 32'(last_code), 32'd5);
        checkOutput("t2_badvaddr", last_bad, 32'h0040_0001);
        checkOutput("t2_latency", 32'(last_rsp_cyc - m_acc), 32'd1);
        checkOutput("t2_bus_cycles", 32'(bus_cnt), 32'd0);

        // Mapped load, TLB miss then TLB hit
        t = mk(32'h0040_0000, 1'b0, 2'd2, 1'b0);
        t.miss = 1'b1;
        applyStimulus(t);
        checkOutput("t3_code", 32'(last_code), 32'd2);
        checkOutput("t3_badvaddr", last_bad, 32'h0040_0000);
        t.miss = 1'b0;
        t.key  = 32'h0040_0000 ^ 32'h0123_4000;
        applyStimulus(t);
        checkOutput("t4_bus_addr", last_bus_addr, 32'h0123_4000);

        // kseg1 load in user mode, then kernel mode
        t = mk(32'hA000_0000, 1'b0, 2'd2, 1'b1);
        applyStimulus(t);
        checkOutput("t5_code", 32'(last_code), 32'd4);
        t.um = 1'b0;
        t.rdata = 32'h0BAD_F00D;
        applyStimulus(t);
        checkOutput("t6_bus_addr", last_bus_addr, 32'h0000_0000);

        // No ack: timeout
        t = mk(32'h8000_0004, 1'b0, 2'd2, 1'b0);
        t.k = 100;
        applyStimulus(t);
        checkOutput("t7_bus_cycles", 32'(bus_cnt), 32'd4);
        checkOutput("t7_code", 32'(last_code), 32'd7);
        checkOutput("t7_badvaddr", last_bad, 32'd0);

        // ack and err together
        t = mk(32'h8000_0008, 1'b0, 2'd2, 1'b0);
        t.k = 1;
        t.err = 1'b1;
        t.err_ack = 1'b1;
        applyStimulus(t);
        checkOutput("t8_code", 32'(last_code), 32'd7);

        // Reset while in BUS, late ack in IDLE, then a normal request
        t = mk(32'h8000_0100, 1'b0, 2'd2, 1'b0);
        t.k = 100;
        startTxn(t);
        repeat (3) begin
            @(negedge clk);
            req_valid = 1'b0;
            driveBus();
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        m_acc  = -100;
        m_rsp  = -100;
        m_nbus = 0;
        @(negedge clk);
        checkOutput("rst_bus_req", 32'(bus_req), 32'd0);
        checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        rst     = 1'b0;
        bus_ack = 1'b1;
        bus_err = 1'b0;
        @(negedge clk);
        bus_ack = 1'b0;
        @(negedge clk);
        checkOutput("late_ack_rsp_valid", 32'(rsp_valid), 32'd0);
        t = mk(32'h8000_0200, 1'b0, 2'd2, 1'b0);
        t.k = 1;
        t.rdata = 32'h1234_5678;
        applyStimulus(t);
        checkOutput("post_rst_rdata", last_rdata, 32'h1234_5678);
        checkOutput("post_rst_latency", 32'(last_rsp_cyc - m_acc), 32'd3);

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            applyStimulus(randTxn());
        end

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
